riscv_core_cache_refill_arbiter: RTL

Shares the single AXI block-transfer port between the instruction-cache controller (read refills) and the data-cache controller (read refills and dirty-block writebacks). It sits between both cache controllers and the AXI master, grants one requester at a time, and forwards that requester's address, direction and write block. It returns the completion pulse and 256-bit read block to the owner only. It never reorders or splits transfers: one grant is exactly one AXI block transaction.

---
 rtl/riscv_core_arb_pkg.sv | 31 +++
 rtl/riscv_core_arb_pick.sv | 44 ++++
 rtl/riscv_core_cache_refill_arbiter.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/riscv_core_arb_pkg.sv
// -----------------------------------------------------------------------------
// riscv_core_arb_pkg
//
// Shared definitions for the cache refill arbiter and the cache tops that
// instantiate it.
//   - DEFAULT_ADDR_WIDTH / DEFAULT_AXI_DATA_WIDTH : default block request geometry
//   - arb_state_e : arbiter FSM states (IDLE, BUSY, RELEASE)
//   - arb_owner_e : which cache controller owns the AXI port
//   - other_owner(): the requester that is not the given one
// -----------------------------------------------------------------------------
package riscv_core_arb_pkg;

  localparam int DEFAULT_ADDR_WIDTH     = 64;
  localparam int DEFAULT_AXI_DATA_WIDTH = 256;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IC = 1'b0,
    OWN_DC = 1'b1
  } arb_owner_e;

  function automatic arb_owner_e other_owner(input arb_owner_e owner);
    return (owner == OWN_IC) ? OWN_DC : OWN_IC;
  endfunction

endpackage

// File: rtl/riscv_core_arb_pick.sv
// -----------------------------------------------------------------------------
// riscv_core_arb_pick
//
// Combinational two-way picker between the icache and dcache requesters.
// A lone requester always wins. On a tie:
//   - RISCV_ARB_ROUND_ROBIN_EN defined : the requester that was not granted
//     last wins (last_owner port present).
//   - undefined                        : the dcache wins (no pointer input).
//
// Ports
//   ic_req     in   icache request level
//   dc_req     in   dcache request level
//   last_owner in   owner of the previous grant (round-robin build only)
//   any_req    out  at least one request is pending
//   winner     out  chosen owner, meaningful only when any_req is high
// -----------------------------------------------------------------------------
module riscv_core_arb_pick
  import riscv_core_arb_pkg::*;
(
  input  logic       ic_req,
  input  logic       dc_req,
`ifdef RISCV_ARB_ROUND_ROBIN_EN
  input  arb_owner_e last_owner,
`endif
  output logic       any_req,
  output arb_owner_e winner
);

  always_comb begin
    // NOTE: every output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    any_req = ic_req | dc_req;
    winner  = OWN_DC;
    if (ic_req && !dc_req) begin
      winner = OWN_IC;
    end
`ifdef RISCV_ARB_ROUND_ROBIN_EN
    else if (ic_req && dc_req) begin
      winner = other_owner(last_owner);
    end
`endif
  end

endmodule

// File: rtl/riscv_core_cache_refill_arbiter.sv
// -----------------------------------------------------------------------------
// riscv_core_cache_refill_arbiter
//
// Shares the single AXI block-transfer port between the icache controller
// (read refills) and the dcache controller (refills and dirty writebacks).
// One grant is exactly one AXI block transaction; transfers are never split or
// reordered. The owner's address, direction and write block are latched at
// grant and held frozen until the transaction completes; the completion pulse
// and read block go back to the owner only.
//
// FSM: IDLE -> BUSY (grant) -> RELEASE (done pulse, one cycle) -> IDLE.
// RELEASE never samples requests, which gives the owner one cycle to drop its
// level request so a stale level is never granted a second time.
//
// Build option: define RISCV_ARB_ROUND_ROBIN_EN for round-robin tie breaking;
// default build uses fixed priority (dcache wins a tie, no pointer flop).
//
// Ports
//   i_clk, i_rst            clock, asynchronous active-high reset
//   i_ic_req, i_ic_addr     icache refill request / block address
//   o_ic_done               one-cycle completion pulse to the icache
//   i_dc_req, i_dc_wr       dcache request / direction (1 writeback, 0 refill)
//   i_dc_addr, i_dc_wdata   dcache block address / writeback block
//   o_dc_done               one-cycle completion pulse to the dcache
//   o_block                 registered read block, valid in the done cycle
//   o_mem_req, o_mem_wr     request / direction to the AXI master
//   o_mem_addr, o_mem_wdata latched block address / writeback block
//   i_mem_done, i_mem_rdata AXI completion pulse / read block
//
// All outputs are flop outputs; no input reaches an output combinationally.
// -----------------------------------------------------------------------------
module riscv_core_cache_refill_arbiter
  import riscv_core_arb_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int AXI_DATA_WIDTH = DEFAULT_AXI_DATA_WIDTH
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_ic_req,
  input  logic [ADDR_WIDTH-1:0]     i_ic_addr,
  output logic                      o_ic_done,
  input  logic                      i_dc_req,
  input  logic                      i_dc_wr,
  input  logic [ADDR_WIDTH-1:0]     i_dc_addr,
  input  logic [AXI_DATA_WIDTH-1:0] i_dc_wdata,
  output logic                      o_dc_done,
  output logic [AXI_DATA_WIDTH-1:0] o_block,
  output logic                      o_mem_req,
  output logic                      o_mem_wr,
  output logic [ADDR_WIDTH-1:0]     o_mem_addr,
  output logic [AXI_DATA_WIDTH-1:0] o_mem_wdata,
  input  logic                      i_mem_done,
  input  logic [AXI_DATA_WIDTH-1:0] i_mem_rdata
);

  arb_state_e state;
  arb_owner_e owner;
  arb_owner_e winner;
  logic       any_req;

`ifdef RISCV_ARB_ROUND_ROBIN_EN
  arb_owner_e last_owner;
`endif

  riscv_core_arb_pick u_pick (
    .ic_req     (i_ic_req),
    .dc_req     (i_dc_req),
`ifdef RISCV_ARB_ROUND_ROBIN_EN
    .last_owner (last_owner),
`endif
    .any_req    (any_req),
    .winner     (winner)
  );

  // NOTE: sequential state uses non-blocking (<=) only, so every flop samples
  // pre-edge values and the block has no evaluation-order dependence.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      // NOTE: the wide datapath registers are reset only because their reset
      // value is visible on the ports; plain storage would not need it.
      state       <= IDLE;
      owner       <= OWN_IC;
      o_mem_req   <= 1'b0;
      o_mem_wr    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_block     <= '0;
      o_ic_done   <= 1'b0;
      o_dc_done   <= 1'b0;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
      // "icache granted last" so the dcache is favoured on the first tie.
      last_owner  <= OWN_IC;
`endif
    end else begin
      // Done flags are pulses: they only ever survive the RELEASE cycle.
      o_ic_done <= 1'b0;
      o_dc_done <= 1'b0;

      unique case (state)
        IDLE: begin
          if (any_req) begin
            owner     <= winner;
            o_mem_req <= 1'b1;
            state     <= BUSY;
`ifdef RISCV_ARB_ROUND_ROBIN_EN
            last_owner <= winner;
`endif
            if (winner == OWN_DC) begin
              o_mem_wr    <= i_dc_wr;
              o_mem_addr  <= i_dc_addr;
              o_mem_wdata <= i_dc_wdata;
            end else begin
              // Icache only ever refills; there is no write block to forward.
              o_mem_wr    <= 1'b0;
              o_mem_addr  <= i_ic_addr;
              o_mem_wdata <= '0;
            end
          end
        end

        BUSY: begin
          // o_mem_* stay frozen here whatever the requesters do.
          if (i_mem_done) begin
            o_block   <= i_mem_rdata;
            o_mem_req <= 1'b0;
            state     <= RELEASE;
            if (owner == OWN_DC) begin
              o_dc_done <= 1'b1;
            end else begin
              o_ic_done <= 1'b1;
            end
          end
        end

        RELEASE: begin
          // Requests are deliberately not sampled here.
          state <= IDLE;
        end

        default: begin
          state     <= IDLE;
          o_mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule
